fft_input_reorder: RTL and testbench
====================================

FFT_INPUT_REORDER -- requirements
Module: fft_input_reorder

Interface
REQ-001 Parameter N_POINTS, default 8, meaning FFT length; SHALL be a power of two, at least 4.
REQ-002 Parameter DATA_WIDTH, default 16, meaning signed sample width per real/imag component.
REQ-003 Port clock  input  1  meaning the single clock; all state SHALL change on its rising edge.
REQ-004 Port reset  input  1  meaning reset, asynchronous, active-low.
REQ-005 Port enable  input  1  meaning run/pause control.
REQ-006 Port in_valid  input  1  meaning in_real/in_imag carry a sample.
REQ-007 Port in_ready  output  1  meaning block accepts a sample this cycle.
REQ-008 Port in_real, in_imag  input  DATA_WIDTH signed  meaning natural-order time-domain sample.
REQ-009 Port out_valid  output  1  meaning even/odd pair is presented.
REQ-010 Port out_ready  input  1  meaning downstream 2-point butterfly consumes the pair this cycle.
REQ-011 Port even_real, even_imag, odd_real, odd_imag  output  DATA_WIDTH signed  meaning first-stage butterfly operands.
REQ-012 Port pair_index  output  log2(N_POINTS)-1  meaning index of the presented pair, 0..N_POINTS/2-1.
REQ-013 Port last_pair  output  1  meaning presented pair is the final pair of the frame.
REQ-014 Port done  output  1  meaning one-cycle pulse when the final pair is consumed.

Function
REQ-015 Block SHALL hold one N_POINTS-entry complex buffer, a write counter wr_count (0..N_POINTS-1) and a pair counter rd_pair (0..N_POINTS/2-1).
REQ-016 FSM states: IDLE, FILL, DRAIN.
REQ-017 IDLE: in_ready=0, out_valid=0; enable=1 moves to FILL next cycle, clearing wr_count.
REQ-018 FILL: in_ready=enable; a sample SHALL be accepted when in_valid & in_ready, written to buffer[bitrev(wr_count)], where bitrev reverses the log2(N_POINTS) address bits.
REQ-019 The accept that writes wr_count=N_POINTS-1 SHALL move to DRAIN, with rd_pair=0, on that edge.
REQ-020 DRAIN: out_valid=enable; even_* = buffer[2*rd_pair], odd_* = buffer[2*rd_pair+1]; in_ready=0.
REQ-021 First out_valid SHALL assert the cycle after the final input accept: latency 1 cycle from last accept.
REQ-022 A pair SHALL be consumed when out_valid & out_ready; rd_pair then increments.
REQ-023 While out_valid=1 and out_ready=0, all output ports SHALL hold stable.
REQ-024 last_pair SHALL equal out_valid & (rd_pair==N_POINTS/2-1).
REQ-025 Consuming the final pair SHALL pulse done for exactly the next cycle, and SHALL move to FILL if enable=1, otherwise to IDLE.
REQ-026 enable=0 in FILL or DRAIN SHALL pause: in_ready=0, out_valid=0, counters and buffer held; resumption SHALL continue exactly where paused.
REQ-027 Whenever out_valid=0, even_*, odd_*, pair_index and last_pair SHALL read 0.
REQ-028 Samples SHALL pass bit-exact; no arithmetic, scaling or sign change.
REQ-029 in_valid while in_ready=0 SHALL be ignored; no sample loss once accepted.

Reset
REQ-030 reset low SHALL immediately force state IDLE, wr_count=0, rd_pair=0, done=0, in_ready=0, out_valid=0 and all data outputs 0, independent of clock.
REQ-031 Buffer contents need not be cleared; they SHALL never be visible before being rewritten in the current frame.
REQ-032 Reset asserted mid-FILL or mid-DRAIN SHALL discard the partial frame; the first frame after release SHALL start with wr_count=0.

Verification
REQ-033 N=8, enable=1, 8 samples real=k, imag=-k (k=0..7), out_ready=1 -> pairs (0,4),(2,6),(1,5),(3,7) on even/odd real, imag negated, pair_index 0..3, last_pair on 4th, done 1 cycle after.
REQ-034 Same frame with out_ready toggling 1,0,0,1,... -> identical pair sequence, outputs stable during stalls, no pair duplicated or dropped.
REQ-035 in_valid gaps of 3 cycles between samples -> only valid samples stored; output order unchanged from REQ-033.
REQ-036 enable dropped for 5 cycles after 4th input and again after 2nd pair -> in_ready/out_valid 0 during pause; final sequence identical to REQ-033.
REQ-037 reset pulsed low after 5th input, then a fresh 8-sample frame real=10+k -> outputs (10,14),(12,16),(11,15),(13,17); no stale data.
REQ-038 Two back-to-back frames with enable held 1 -> FILL re-entered the cycle after done; second frame reordered correctly.

Source files
------------

// File: rtl/fft_input_reorder.sv
// Buffers one natural-order frame in bit-reversed order, then presents it
// as even/odd operand pairs for the first radix-2 butterfly stage.
module fft_input_reorder #(
    parameter int unsigned N_POINTS   = 8,
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              enable,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic signed [DATA_WIDTH-1:0]      in_real,
    input  logic signed [DATA_WIDTH-1:0]      in_imag,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic signed [DATA_WIDTH-1:0]      even_real,
    output logic signed [DATA_WIDTH-1:0]      even_imag,
    output logic signed [DATA_WIDTH-1:0]      odd_real,
    output logic signed [DATA_WIDTH-1:0]      odd_imag,
    output logic [$clog2(N_POINTS)-2:0]       pair_index,
    output logic                              last_pair,
    output logic                              done
);

    localparam int unsigned AW = $clog2(N_POINTS);
    localparam int unsigned PW = AW - 1;

    typedef enum logic [1:0] {StIdle, StFill, StDrain} state_e;

    state_e            state_q, state_d;
    logic [AW-1:0]     wr_count_q, wr_count_d;
    logic [PW-1:0]     rd_pair_q, rd_pair_d;
    logic              done_q, done_d;

    logic signed [DATA_WIDTH-1:0] buf_re_q [N_POINTS];
    logic signed [DATA_WIDTH-1:0] buf_im_q [N_POINTS];

    logic [AW-1:0] wr_addr;
    logic [AW-1:0] even_addr;
    logic [AW-1:0] odd_addr;
    logic          accept;
    logic          consume;
    logic          last_rd;

    always_comb begin
        wr_addr = '0;
        for (int i = 0; i < AW; i++) begin
            wr_addr[i] = wr_count_q[AW-1-i];
        end
    end

    assign even_addr = {rd_pair_q, 1'b0};
    assign odd_addr  = {rd_pair_q, 1'b1};

    assign in_ready  = (state_q == StFill) && enable;
    assign out_valid = (state_q == StDrain) && enable;
    assign accept    = in_ready && in_valid;
    assign consume   = out_valid && out_ready;
    assign last_rd   = (rd_pair_q == PW'(N_POINTS / 2 - 1));
    assign done      = done_q;

    always_comb begin
        state_d    = state_q;
        wr_count_d = wr_count_q;
        rd_pair_d  = rd_pair_q;
        done_d     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (enable) begin
                    state_d    = StFill;
                    wr_count_d = '0;
                end
            end
            StFill: begin
                if (accept) begin
                    if (wr_count_q == AW'(N_POINTS - 1)) begin
                        state_d    = StDrain;
                        wr_count_d = '0;
                        rd_pair_d  = '0;
                    end else begin
                        wr_count_d = wr_count_q + 1'b1;
                    end
                end
            end
            StDrain: begin
                if (consume) begin
                    if (last_rd) begin
                        done_d    = 1'b1;
                        rd_pair_d = '0;
                        state_d   = enable ? StFill : StIdle;
                    end else begin
                        rd_pair_d = rd_pair_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs are gated by out_valid so nothing stale leaks while idle or paused.
    always_comb begin
        even_real  = '0;
        even_imag  = '0;
        odd_real   = '0;
        odd_imag   = '0;
        pair_index = '0;
        last_pair  = 1'b0;
        if (out_valid) begin
            even_real  = buf_re_q[even_addr];
            even_imag  = buf_im_q[even_addr];
            odd_real   = buf_re_q[odd_addr];
            odd_imag   = buf_im_q[odd_addr];
            pair_index = rd_pair_q;
            last_pair  = last_rd;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            wr_count_q <= '0;
            rd_pair_q  <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_count_q <= wr_count_d;
            rd_pair_q  <= rd_pair_d;
            done_q     <= done_d;
        end
    end

    // Sample storage needs no reset: every entry is rewritten before DRAIN.
    always_ff @(posedge clock) begin
        if (accept) begin
            buf_re_q[wr_addr] <= in_real;
            buf_im_q[wr_addr] <= in_imag;
        end
    end

endmodule

// File: tb/tb_fft_input_reorder.sv
// Randomized scoreboard bench for fft_input_reorder; expected pairs come from
// a frame-level model (output slot j holds input sample bitrev(j)).
module tb_fft_input_reorder;

    localparam int DW = 16;
    localparam int N  = 8;
    localparam int AW = 3;
    localparam int PW = 2;

    logic                 clock = 1'b0;
    logic                 reset = 1'b0;
    logic                 enable = 1'b0;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic signed [DW-1:0] in_real = '0;
    logic signed [DW-1:0] in_imag = '0;
    logic                 out_valid;
    logic                 out_ready = 1'b0;
    logic signed [DW-1:0] even_real, even_imag, odd_real, odd_imag;
    logic [PW-1:0]        pair_index;
    logic                 last_pair;
    logic                 done;

    fft_input_reorder #(.N_POINTS(N), .DATA_WIDTH(DW)) dut (
        .clock(clock), .reset(reset), .enable(enable),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_real(in_real), .in_imag(in_imag),
        .out_valid(out_valid), .out_ready(out_ready),
        .even_real(even_real), .even_imag(even_imag),
        .odd_real(odd_real), .odd_imag(odd_imag),
        .pair_index(pair_index), .last_pair(last_pair), .done(done)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic signed [DW-1:0] e_re;
        logic signed [DW-1:0] e_im;
        logic signed [DW-1:0] o_re;
        logic signed [DW-1:0] o_im;
        logic [PW-1:0]        idx;
        logic                 last;
    } pair_t;

    pair_t                exp_q[$];
    logic signed [DW-1:0] frame_re[$];
    logic signed [DW-1:0] frame_im[$];
    int                   checks = 0;
    int                   errors = 0;
    int                   pairs_consumed = 0;
    int                   ready_mode = 0;
    int                   ready_cnt = 0;
    logic                 exp_done = 1'b0;
    logic                 lat_pending = 1'b0;

    task automatic chk(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int bitrev(input int x);
        int r = 0;
        int v = x;
        for (int b = 0; b < AW; b++) begin
            r = r * 2 + (v % 2);
            v = v / 2;
        end
        return r;
    endfunction

    // Frame complete: slot j of the reordered frame is input sample bitrev(j).
    task automatic push_frame_expectations();
        pair_t e;
        for (int p = 0; p < N / 2; p++) begin
            e.e_re = frame_re[bitrev(2 * p)];
            e.e_im = frame_im[bitrev(2 * p)];
            e.o_re = frame_re[bitrev(2 * p + 1)];
            e.o_im = frame_im[bitrev(2 * p + 1)];
            e.idx  = PW'(p);
            e.last = (p == N / 2 - 1);
            exp_q.push_back(e);
        end
        frame_re.delete();
        frame_im.delete();
    endtask

    always @(negedge clock) begin
        pair_t e;
        if (!reset) begin
            chk("reset_flags", {60'd0, in_ready, out_valid, done, last_pair}, 0);
            chk("reset_data", ((even_real | even_imag | odd_real | odd_imag) != 0)
                || (pair_index != 0), 0);
            exp_q.delete();
            frame_re.delete();
            frame_im.delete();
            exp_done = 1'b0;
            lat_pending = 1'b0;
        end else begin
            chk("done", done, exp_done);
            if (done) chk("refill_after_done", in_ready, enable);
            exp_done = 1'b0;
            if (!enable) chk("pause", {62'd0, in_ready, out_valid}, 0);
            if (lat_pending) begin
                if (enable) chk("first_out_latency", out_valid, 1);
                lat_pending = 1'b0;
            end
            if (out_valid) begin
                chk("in_ready_in_drain", in_ready, 0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_pair", 1, 0);
                end else begin
                    e = exp_q[0];
                    chk("even_real", even_real, e.e_re);
                    chk("even_imag", even_imag, e.e_im);
                    chk("odd_real", odd_real, e.o_re);
                    chk("odd_imag", odd_imag, e.o_im);
                    chk("pair_index", pair_index, e.idx);
                    chk("last_pair", last_pair, e.last);
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        pairs_consumed++;
                        if (e.last) exp_done = 1'b1;
                    end
                end
            end else begin
                chk("zero_when_invalid", ((even_real | even_imag | odd_real | odd_imag) != 0)
                    || (pair_index != 0) || last_pair, 0);
            end
            if (in_valid && in_ready) begin
                frame_re.push_back(in_real);
                frame_im.push_back(in_imag);
                if (frame_re.size() == N) begin
                    push_frame_expectations();
                    lat_pending = 1'b1;
                end
            end
        end
    end

    always begin
        @(posedge clock);
        #1;
        case (ready_mode)
            0: out_ready = 1'b1;
            1: out_ready = (ready_cnt % 3 == 0);
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
        ready_cnt++;
    end

    task automatic send_sample(input logic signed [DW-1:0] re, input logic signed [DW-1:0] im,
                               input int gap);
        for (int g = 0; g < gap; g++) begin
            in_real = DW'($urandom);
            in_imag = DW'($urandom);
            @(posedge clock);
            #1;
        end
        in_valid = 1'b1;
        in_real  = re;
        in_imag  = im;
        for (int t = 0; ; t++) begin
            @(negedge clock);
            if (in_ready) break;
            if (t > 500) begin
                chk("accept_timeout", 1, 0);
                break;
            end
        end
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        in_real  = DW'($urandom);
        in_imag  = DW'($urandom);
    endtask

    task automatic send_frame(input int base, input int gap, input bit rand_data);
        for (int k = 0; k < N; k++) begin
            if (rand_data)
                send_sample(DW'($urandom), DW'($urandom), $urandom_range(0, 3));
            else
                send_sample(DW'(base + k), DW'(-(base + k)), gap);
        end
    endtask

    task automatic wait_drained();
        for (int t = 0; t < 3000 && exp_q.size() != 0; t++) @(posedge clock);
        if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 0);
        repeat (2) @(posedge clock);
        #1;
    endtask

    initial begin
        int c0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;

        // Basic frame, then stalled output, then sparse input.
        enable = 1'b1;
        ready_mode = 0;
        send_frame(0, 0, 1'b0);
        wait_drained();
        ready_mode = 1;
        send_frame(0, 0, 1'b0);
        wait_drained();
        ready_mode = 0;
        send_frame(0, 3, 1'b0);
        wait_drained();

        // Pause after 4th input and after 2nd pair.
        c0 = pairs_consumed;
        for (int k = 0; k < 4; k++) send_sample(DW'(k), DW'(-k), 0);
        enable = 1'b0;
        repeat (5) @(posedge clock);
        #1;
        enable = 1'b1;
        for (int k = 4; k < N; k++) send_sample(DW'(k), DW'(-k), 0);
        for (int t = 0; t < 200 && pairs_consumed < c0 + 2; t++) @(posedge clock);
        chk("pairs_before_pause", pairs_consumed >= c0 + 2, 1);
        #1;
        enable = 1'b0;
        repeat (5) @(posedge clock);
        #1;
        enable = 1'b1;
        wait_drained();

        // Reset mid-FILL discards the partial frame.
        for (int k = 0; k < 5; k++) send_sample(DW'(k), DW'(-k), 0);
        reset = 1'b0;
        #1;
        chk("async_reset", {62'd0, in_ready, out_valid}, 0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        send_frame(10, 0, 1'b0);
        wait_drained();

        // Back-to-back frames with enable held high.
        send_frame(20, 0, 1'b0);
        send_frame(30, 0, 1'b0);
        wait_drained();

        // Randomized frames with random gaps and back-pressure.
        ready_mode = 2;
        for (int f = 0; f < 6; f++) send_frame(0, 0, 1'b1);
        wait_drained();

        chk("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
